// File: rtl/watch_mode_ctrl.sv
// rtl/watch_mode_ctrl.sv - front-panel button, mode and countdown-timer controller
//
// Purpose: debounces the five raw buttons, steps the display mode, runs the
// countdown timer state machine (SET/RUN/PAUSE/DONE) with its blinking alarm,
// emits one-cycle mode-gated command pulses, and registers the selected digit
// bus onto the shared display.
//
// Ports:
//   clk100MHz       system clock
//   rst_n           asynchronous active-low reset
//   tick_1s         one-cycle 1 Hz enable
//   btn_*           raw asynchronous buttons (mode, start, sec, tensec, min)
//   timer_zero      countdown datapath reads 00:00
//   clk/sw/tmr_digits  16-bit digit buses {tenmin,onemin,tensec,onesec}
//   sel             display mode 00 clock, 01 stopwatch, 10 timer
//   tmr_run         countdown enable (state RUN)
//   tmr_inc_*       one-cycle timer increment pulses
//   sw_toggle       one-cycle stopwatch run toggle
//   alarm           blinking alarm level while DONE
//   disp_digits     registered display bus
module watch_mode_ctrl #(
  parameter int         DEBOUNCE_CYCLES = 1_000_000,
  parameter int         ALARM_SECONDS   = 10,
  parameter logic [3:0] BLANK_CODE      = 4'hF
) (
  input  logic        clk100MHz,
  input  logic        rst_n,
  input  logic        tick_1s,
  input  logic        btn_mode,
  input  logic        btn_start,
  input  logic        btn_sec,
  input  logic        btn_tensec,
  input  logic        btn_min,
  input  logic        timer_zero,
  input  logic [15:0] clk_digits,
  input  logic [15:0] sw_digits,
  input  logic [15:0] tmr_digits,
  output logic [1:0]  sel,
  output logic        tmr_run,
  output logic        tmr_inc_sec,
  output logic        tmr_inc_tensec,
  output logic        tmr_inc_min,
  output logic        sw_toggle,
  output logic        alarm,
  output logic [15:0] disp_digits
);

  localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int ACW = $clog2(ALARM_SECONDS + 1);
  localparam logic [DCW-1:0] DB_LAST = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [ACW-1:0] AL_LAST = ACW'(ALARM_SECONDS - 1);

  localparam logic [1:0] SEL_CLK = 2'b00;
  localparam logic [1:0] SEL_SW  = 2'b01;
  localparam logic [1:0] SEL_TMR = 2'b10;

  typedef enum logic [1:0] {ST_SET, ST_RUN, ST_PAUSE, ST_DONE} tmr_state_e;

  // Button vector order: 0 mode, 1 start, 2 sec, 3 tensec, 4 min.
  logic [4:0]     btn_raw;
  logic [4:0]     sync1_q, sync2_q, db_q, db_prev_q, arm_q;
  logic [DCW-1:0] db_cnt_q [5];
  logic [1:0]     settle_q;
  logic           settled;
  logic [4:0]     press;

  assign btn_raw = {btn_min, btn_tensec, btn_sec, btn_start, btn_mode};
  // The synchroniser holds reset values for two cycles; only after that does
  // sync2 reflect the real pin, so arming waits for it.
  assign settled = (settle_q == 2'd2);
  // arm_q blocks the press of a button that was already held at reset release.
  assign press   = db_q & ~db_prev_q & arm_q;

  always_ff @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      arm_q     <= '0;
      settle_q  <= '0;
      for (int i = 0; i < 5; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      db_prev_q <= db_q;
      if (!settled) settle_q <= settle_q + 2'd1;
      for (int i = 0; i < 5; i++) begin
        if (settled && !sync2_q[i]) arm_q[i] <= 1'b1;
        if (sync2_q[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          db_q[i]     <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DCW'(1);
        end
      end
    end
  end

  logic p_mode, p_start;
  assign p_mode  = press[0];
  assign p_start = press[1];

  tmr_state_e     state_q, state_d;
  logic           alarm_q, alarm_d;
  logic [ACW-1:0] acnt_q, acnt_d;
  logic [1:0]     sel_q, sel_d;
  logic           tmr_run_q;
  logic [2:0]     inc_q, inc_d;
  logic           sw_toggle_q, sw_toggle_d;
  logic [15:0]    disp_q, disp_d;
  logic           sel_tmr;
  logic           blank;

  assign sel_tmr = (sel_q == SEL_TMR);
  assign blank   = sel_tmr && (state_q == ST_DONE) && !alarm_q;

  always_comb begin
    state_d     = state_q;
    alarm_d     = alarm_q;
    acnt_d      = acnt_q;
    sel_d       = sel_q;
    inc_d       = '0;
    sw_toggle_d = 1'b0;
    disp_d      = clk_digits;

    case (state_q)
      ST_SET, ST_PAUSE: begin
        if (p_start && sel_tmr && !timer_zero) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (timer_zero)               state_d = ST_DONE;
        else if (p_start && sel_tmr)  state_d = ST_PAUSE;
      end
      ST_DONE: begin
        // Acknowledge works from any mode; otherwise blink until timeout.
        if (p_start) begin
          state_d = ST_SET;
        end else if (tick_1s) begin
          if (acnt_q == AL_LAST) begin
            state_d = ST_SET;
          end else begin
            alarm_d = !alarm_q;
            acnt_d  = acnt_q + ACW'(1);
          end
        end
      end
      default: state_d = ST_SET;
    endcase

    if (state_d == ST_DONE && state_q != ST_DONE) begin
      alarm_d = 1'b1;
      acnt_d  = '0;
    end else if (state_d != ST_DONE) begin
      alarm_d = 1'b0;
      acnt_d  = '0;
    end

    // Increments are dropped when start arrives in the same cycle, so a
    // start+inc chord never edits the value being started.
    if (sel_tmr && (state_q == ST_SET || state_q == ST_PAUSE) && !p_start)
      inc_d = press[4:2];

    sw_toggle_d = p_start && (sel_q == SEL_SW) && (state_q != ST_DONE);

    if (p_mode) sel_d = (sel_q == SEL_TMR) ? SEL_CLK : sel_q + 2'd1;

    case (sel_q)
      SEL_SW:  disp_d = sw_digits;
      SEL_TMR: disp_d = blank ? {4{BLANK_CODE}} : tmr_digits;
      default: disp_d = clk_digits;
    endcase
  end

  always_ff @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SET;
      alarm_q     <= 1'b0;
      acnt_q      <= '0;
      sel_q       <= SEL_CLK;
      tmr_run_q   <= 1'b0;
      inc_q       <= '0;
      sw_toggle_q <= 1'b0;
      disp_q      <= '0;
    end else begin
      state_q     <= state_d;
      alarm_q     <= alarm_d;
      acnt_q      <= acnt_d;
      sel_q       <= sel_d;
      tmr_run_q   <= (state_d == ST_RUN);
      inc_q       <= inc_d;
      sw_toggle_q <= sw_toggle_d;
      disp_q      <= disp_d;
    end
  end

  assign sel            = sel_q;
  assign tmr_run        = tmr_run_q;
  assign tmr_inc_sec    = inc_q[0];
  assign tmr_inc_tensec = inc_q[1];
  assign tmr_inc_min    = inc_q[2];
  assign sw_toggle      = sw_toggle_q;
  assign alarm          = alarm_q;
  assign disp_digits    = disp_q;

endmodule

// File: tb/tb_watch_mode_ctrl.sv
// tb/tb_watch_mode_ctrl.sv - self-checking bench for watch_mode_ctrl
module tb_watch_mode_ctrl;

  localparam int DB = 4;
  localparam int AS = 3;
  localparam int M_SET = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        b_mode = 1'b0, b_start = 1'b0, b_sec = 1'b0, b_ten = 1'b0, b_min = 1'b0;
  logic        tz = 1'b0;
  logic [15:0] clk_d, sw_d, tmr_d;
  logic [1:0]  sel;
  logic        tmr_run, inc_sec, inc_ten, inc_min, sw_toggle, alarm;
  logic [15:0] disp;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_sec = 0, n_ten = 0, n_min = 0, n_sw = 0, last_sec = -1;

  int m_sel = 0, m_state = M_SET;
  bit m_alarm = 1'b0;
  int e_sec = 0, e_ten = 0, e_min = 0, e_sw = 0;

  watch_mode_ctrl #(.DEBOUNCE_CYCLES(DB), .ALARM_SECONDS(AS), .BLANK_CODE(4'hF)) dut (
    .clk100MHz(clk), .rst_n(rst_n), .tick_1s(tick),
    .btn_mode(b_mode), .btn_start(b_start), .btn_sec(b_sec), .btn_tensec(b_ten), .btn_min(b_min),
    .timer_zero(tz), .clk_digits(clk_d), .sw_digits(sw_d), .tmr_digits(tmr_d),
    .sel(sel), .tmr_run(tmr_run), .tmr_inc_sec(inc_sec), .tmr_inc_tensec(inc_ten),
    .tmr_inc_min(inc_min), .sw_toggle(sw_toggle), .alarm(alarm), .disp_digits(disp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Count every high sample of each pulse output; a stretched pulse shows as extra counts.
  always @(negedge clk) begin
    if (inc_sec) begin n_sec++; last_sec = cyc; end
    if (inc_ten) n_ten++;
    if (inc_min) n_min++;
    if (sw_toggle) n_sw++;
  end

  task automatic new_digits;
    clk_d = 16'($urandom_range(0, 16'h3FFF));
    sw_d  = 16'h4000 | 16'($urandom_range(0, 16'h3FFF));
    tmr_d = 16'h8000 | 16'($urandom_range(0, 16'h3FFF));
  endtask

  function automatic logic [15:0] exp_disp(input int s);
    if (s == 0) return clk_d;
    if (s == 1) return sw_d;
    if (m_state == M_DONE && !m_alarm) return 16'hFFFF;
    return tmr_d;
  endfunction

  // Mask bits: 0 mode, 1 start, 2 sec, 3 tensec, 4 min.
  task automatic model_press(input logic [4:0] m);
    int sp;
    sp = m_sel;
    if (sp == 2 && (m_state == M_SET || m_state == M_PAUSE) && !m[1]) begin
      e_sec += int'(m[2]); e_ten += int'(m[3]); e_min += int'(m[4]);
    end
    if (m[1] && sp == 1 && m_state != M_DONE) e_sw++;
    if (m[1]) begin
      if (m_state == M_DONE) begin
        m_state = M_SET; m_alarm = 1'b0;
      end else if (sp == 2) begin
        if (m_state == M_RUN) m_state = M_PAUSE;
        else if (!tz) m_state = M_RUN;
      end
    end
    if (m[0]) m_sel = (m_sel + 1) % 3;
  endtask

  task automatic drive_press(input logic [4:0] m);
    @(negedge clk);
    {b_min, b_ten, b_sec, b_start, b_mode} = m;
    repeat (10) @(negedge clk);
    {b_min, b_ten, b_sec, b_start, b_mode} = '0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (sel !== 2'b00) begin errors++; $display("FAIL reset_sel got=%b exp=00", sel); end
    checks++; if (tmr_run !== 1'b0) begin errors++; $display("FAIL reset_run got=%b exp=0", tmr_run); end
    checks++; if (alarm !== 1'b0) begin errors++; $display("FAIL reset_alarm got=%b exp=0", alarm); end
    checks++; if (disp !== 16'h0) begin errors++; $display("FAIL reset_disp got=%h exp=0000", disp); end
    checks++; if ({inc_sec, inc_ten, inc_min, sw_toggle} !== 4'b0) begin
      errors++; $display("FAIL reset_pulses got=%b exp=0000", {inc_sec, inc_ten, inc_min, sw_toggle});
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (disp !== clk_d) begin errors++; $display("FAIL post_reset_disp got=%h exp=%h", disp, clk_d); end
  endtask

  task automatic test_mode;
    for (int i = 0; i < 3; i++) begin
      int w;
      int ns;
      ns = (m_sel + 1) % 3;
      @(negedge clk);
      b_mode = 1'b1;
      w = 0;
      while (sel === 2'(m_sel) && w < 20) begin @(negedge clk); w++; end
      checks++; if (sel !== 2'(ns)) begin errors++; $display("FAIL mode_sel step=%0d got=%b exp=%0d", i, sel, ns); end
      checks++; if (disp !== exp_disp(m_sel)) begin errors++; $display("FAIL mode_disp_lag step=%0d got=%h exp=%h", i, disp, exp_disp(m_sel)); end
      @(negedge clk);
      checks++; if (disp !== exp_disp(ns)) begin errors++; $display("FAIL mode_disp step=%0d got=%h exp=%h", i, disp, exp_disp(ns)); end
      b_mode = 1'b0;
      repeat (10) @(negedge clk);
      m_sel = ns;
    end
  endtask

  task automatic test_debounce;
    int base, t0;
    drive_press(5'b00001); model_press(5'b00001);
    drive_press(5'b00001); model_press(5'b00001);
    checks++; if (sel !== 2'b10) begin errors++; $display("FAIL deb_sel got=%b exp=10", sel); end
    @(negedge clk);
    base = n_sec;
    for (int i = 0; i < 4; i++) begin
      b_sec = 1'b1; repeat (2) @(negedge clk);
      b_sec = 1'b0; repeat (2) @(negedge clk);
    end
    b_sec = 1'b1;
    t0 = cyc;
    repeat (10) @(negedge clk);
    b_sec = 1'b0;
    repeat (10) @(negedge clk);
    e_sec++;
    checks++; if (n_sec - base !== 1) begin errors++; $display("FAIL deb_count got=%0d exp=1", n_sec - base); end
    checks++; if (last_sec !== t0 + 7) begin errors++; $display("FAIL deb_latency got=%0d exp=%0d", last_sec - t0, 7); end
  endtask

  task automatic test_run_pause;
    drive_press(5'b00010); model_press(5'b00010);
    checks++; if (tmr_run !== 1'b1) begin errors++; $display("FAIL run_start got=%b exp=1", tmr_run); end
    drive_press(5'b00100); model_press(5'b00100);
    checks++; if (n_sec !== e_sec) begin errors++; $display("FAIL run_inc_dropped got=%0d exp=%0d", n_sec, e_sec); end
    drive_press(5'b00010); model_press(5'b00010);
    checks++; if (tmr_run !== 1'b0) begin errors++; $display("FAIL pause got=%b exp=0", tmr_run); end
    drive_press(5'b10000); model_press(5'b10000);
    checks++; if (n_min !== e_min) begin errors++; $display("FAIL pause_inc_min got=%0d exp=%0d", n_min, e_min); end
  endtask

  task automatic test_done_alarm;
    bit exp_al [3];
    exp_al[0] = 1'b0; exp_al[1] = 1'b1; exp_al[2] = 1'b0;
    drive_press(5'b00010); model_press(5'b00010);
    tz = 1'b1;
    @(negedge clk);
    m_state = M_DONE; m_alarm = 1'b1;
    checks++; if (alarm !== 1'b1) begin errors++; $display("FAIL done_alarm got=%b exp=1", alarm); end
    checks++; if (tmr_run !== 1'b0) begin errors++; $display("FAIL done_run got=%b exp=0", tmr_run); end
    @(negedge clk);
    checks++; if (disp !== tmr_d) begin errors++; $display("FAIL done_disp_on got=%h exp=%h", disp, tmr_d); end
    for (int i = 0; i < 3; i++) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      checks++; if (alarm !== exp_al[i]) begin errors++; $display("FAIL alarm_tick%0d got=%b exp=%b", i, alarm, exp_al[i]); end
      repeat (2) @(negedge clk);
      if (i == 0) begin
        checks++; if (disp !== 16'hFFFF) begin errors++; $display("FAIL done_blank got=%h exp=ffff", disp); end
      end
    end
    m_state = M_SET; m_alarm = 1'b0;
    checks++; if (tmr_run !== 1'b0) begin errors++; $display("FAIL alarm_timeout_run got=%b exp=0", tmr_run); end
    drive_press(5'b01000); model_press(5'b01000);
    checks++; if (n_ten !== e_ten) begin errors++; $display("FAIL timeout_set_inc got=%0d exp=%0d", n_ten, e_ten); end
    tz = 1'b0;
  endtask

  task automatic test_done_ack;
    drive_press(5'b00010); model_press(5'b00010);
    tz = 1'b1;
    repeat (2) @(negedge clk);
    m_state = M_DONE; m_alarm = 1'b1;
    drive_press(5'b00001); model_press(5'b00001);
    checks++; if (alarm !== 1'b1) begin errors++; $display("FAIL ack_mode_keeps_done got=%b exp=1", alarm); end
    checks++; if (disp !== exp_disp(m_sel)) begin errors++; $display("FAIL ack_disp got=%h exp=%h", disp, exp_disp(m_sel)); end
    drive_press(5'b00010); model_press(5'b00010);
    checks++; if (alarm !== 1'b0) begin errors++; $display("FAIL ack_alarm got=%b exp=0", alarm); end
    checks++; if (n_sw !== e_sw) begin errors++; $display("FAIL ack_no_sw got=%0d exp=%0d", n_sw, e_sw); end
    drive_press(5'b00001); model_press(5'b00001);
    drive_press(5'b00010); model_press(5'b00010);
    checks++; if (n_sw !== e_sw) begin errors++; $display("FAIL sw_toggle got=%0d exp=%0d", n_sw, e_sw); end
    drive_press(5'b00001); model_press(5'b00001);
    drive_press(5'b00010); model_press(5'b00010);
    checks++; if (tmr_run !== 1'b0) begin errors++; $display("FAIL start_at_zero got=%b exp=0", tmr_run); end
    tz = 1'b0;
  endtask

  task automatic test_back_to_back;
    drive_press(5'b00110); model_press(5'b00110);
    checks++; if (tmr_run !== 1'b1) begin errors++; $display("FAIL chord_run got=%b exp=1", tmr_run); end
    checks++; if (n_sec !== e_sec) begin errors++; $display("FAIL chord_no_inc got=%0d exp=%0d", n_sec, e_sec); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    b_mode = 1'b1;
    #1;
    checks++; if ({sel, tmr_run, alarm, inc_sec, inc_ten, inc_min, sw_toggle} !== 8'b0) begin
      errors++; $display("FAIL async_reset_ctl got=%b exp=00000000", {sel, tmr_run, alarm, inc_sec, inc_ten, inc_min, sw_toggle});
    end
    checks++; if (disp !== 16'h0) begin errors++; $display("FAIL async_reset_disp got=%h exp=0000", disp); end
    m_sel = 0; m_state = M_SET; m_alarm = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (sel !== 2'b00) begin errors++; $display("FAIL held_through_reset got=%b exp=00", sel); end
    b_mode = 1'b0;
    repeat (12) @(negedge clk);
    drive_press(5'b00001); model_press(5'b00001);
    checks++; if (sel !== 2'(m_sel)) begin errors++; $display("FAIL repress_after_reset got=%b exp=%0d", sel, m_sel); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++) begin
      logic [4:0] m;
      new_digits();
      m = 5'($urandom_range(1, 31));
      drive_press(m); model_press(m);
      checks++; if (sel !== 2'(m_sel)) begin errors++; $display("FAIL rnd%0d_sel got=%b exp=%0d", i, sel, m_sel); end
      checks++; if (tmr_run !== (m_state == M_RUN)) begin errors++; $display("FAIL rnd%0d_run got=%b exp=%0d", i, tmr_run, m_state == M_RUN); end
      checks++; if (n_sec !== e_sec) begin errors++; $display("FAIL rnd%0d_sec got=%0d exp=%0d", i, n_sec, e_sec); end
      checks++; if (n_ten !== e_ten) begin errors++; $display("FAIL rnd%0d_ten got=%0d exp=%0d", i, n_ten, e_ten); end
      checks++; if (n_min !== e_min) begin errors++; $display("FAIL rnd%0d_min got=%0d exp=%0d", i, n_min, e_min); end
      checks++; if (n_sw !== e_sw) begin errors++; $display("FAIL rnd%0d_sw got=%0d exp=%0d", i, n_sw, e_sw); end
      checks++; if (disp !== exp_disp(m_sel)) begin errors++; $display("FAIL rnd%0d_disp got=%h exp=%h", i, disp, exp_disp(m_sel)); end
    end
  endtask

  initial begin
    new_digits();
    test_reset();
    test_mode();
    test_debounce();
    test_run_pause();
    test_done_alarm();
    test_done_ack();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
